// File: rtl/barcode_pkg.sv
// Shared types and constants for the barcode self-checkout controller:
// FSM state encoding, coin values and the space-padded status strings.
package barcode_pkg;

    localparam int MSG_LEN = 26;
    localparam int MSG_W   = 8 * MSG_LEN;

    localparam logic [4:0] COIN_HI = 5'd10;
    localparam logic [4:0] COIN_LO = 5'd2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_PAY = 3'd1,
        ST_CHANGE   = 3'd2,
        ST_DONE     = 3'd3,
        ST_REFUND   = 3'd4
    } state_e;

    typedef logic [MSG_W-1:0] msg_t;

    // First character lands in the top byte; the tail is padded with ASCII spaces.
    localparam msg_t MSG_SCAN_ITEM    = {"SCAN ITEM",          {17{8'h20}}};
    localparam msg_t MSG_INSERT_PAY   = {"INSERT PAYMENT",     {12{8'h20}}};
    localparam msg_t MSG_DISPENSING   = {"DISPENSING CHANGE",  {9{8'h20}}};
    localparam msg_t MSG_THANK_YOU    = {"THANK YOU",          {17{8'h20}}};
    localparam msg_t MSG_INSUFFICIENT = {"INSUFFICIENT FUNDS", {8{8'h20}}};

endpackage

// File: rtl/barcode_msg_rom.sv
// Status-line ROM: maps the checkout FSM state to its 26-char ASCII message.
// Only present when BARCODE_MESSAGE_EN is defined.
`ifdef BARCODE_MESSAGE_EN
module barcode_msg_rom
    import barcode_pkg::*;
(
    input  logic [2:0]       state,
    output logic [MSG_W-1:0] message
);

    always_comb begin
        case (state)
            ST_IDLE:     message = MSG_SCAN_ITEM;
            ST_WAIT_PAY: message = MSG_INSERT_PAY;
            ST_CHANGE:   message = MSG_DISPENSING;
            ST_DONE:     message = MSG_THANK_YOU;
            ST_REFUND:   message = MSG_INSUFFICIENT;
            default:     message = MSG_SCAN_ITEM;
        endcase
    end

endmodule
`endif

// File: rtl/barcode_checkout.sv
// Self-checkout controller: latches price and payment, then pays change greedily
// as 10-unit and 2-unit coin pulses. Status text enabled by BARCODE_MESSAGE_EN.
module barcode_checkout
    import barcode_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       I,
    input  logic [4:0]       PG,
    output logic             DEZ,
    output logic             DOIS,
    output logic             FIM,
    output logic [4:0]       moneyState,
    output logic [4:0]       moneyToGive,
    output logic [2:0]       mainState,
    output logic [MSG_W-1:0] message
);

    state_e     state_q, state_d;
    logic [4:0] price_q, price_d;
    logic [4:0] money_state_q, money_state_d;
    logic [4:0] money_to_give_q, money_to_give_d;
    logic       dez_q, dez_d;
    logic       dois_q, dois_d;
    logic       fim_q, fim_d;

    logic scan_valid, pay_valid, pay_enough, inputs_idle, can_dez, can_dois;

    assign scan_valid  = (I != 5'd0);
    assign pay_valid   = (PG != 5'd0);
    assign pay_enough  = (PG >= price_q);
    assign inputs_idle = !scan_valid && !pay_valid;
    assign can_dez     = (money_to_give_q >= COIN_HI);
    assign can_dois    = (money_to_give_q >= COIN_LO);

    // NOTE: async reset flops use non-blocking assignments so every register
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (scan_valid) state_d = ST_WAIT_PAY;
            ST_WAIT_PAY: if (pay_valid)  state_d = pay_enough ? ST_CHANGE : ST_REFUND;
            ST_REFUND:   state_d = ST_CHANGE;
            ST_CHANGE:   if (!can_dois)  state_d = ST_DONE;
            ST_DONE:     if (inputs_idle) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // NOTE: every signal assigned here gets a default first, so no path
    // through the case leaves one unassigned and infers a latch.
    always_comb begin
        price_d         = price_q;
        money_state_d   = money_state_q;
        money_to_give_d = money_to_give_q;
        dez_d           = 1'b0;
        dois_d          = 1'b0;
        fim_d           = (state_d == ST_DONE);
        case (state_q)
            ST_IDLE: begin
                if (scan_valid) begin
                    price_d       = I;
                    money_state_d = 5'd0;
                end
            end
            ST_WAIT_PAY: begin
                if (pay_valid) begin
                    money_state_d   = PG;
                    money_to_give_d = pay_enough ? (PG - price_q) : PG;
                end
            end
            ST_CHANGE: begin
                // Greedy: prefer the large coin; a residue below COIN_LO stays put.
                if (can_dez) begin
                    dez_d           = 1'b1;
                    money_to_give_d = money_to_give_q - COIN_HI;
                end else if (can_dois) begin
                    dois_d          = 1'b1;
                    money_to_give_d = money_to_give_q - COIN_LO;
                end
            end
            ST_DONE: begin
                if (inputs_idle) money_to_give_d = 5'd0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            price_q         <= 5'd0;
            money_state_q   <= 5'd0;
            money_to_give_q <= 5'd0;
            dez_q           <= 1'b0;
            dois_q          <= 1'b0;
            fim_q           <= 1'b0;
        end else begin
            price_q         <= price_d;
            money_state_q   <= money_state_d;
            money_to_give_q <= money_to_give_d;
            dez_q           <= dez_d;
            dois_q          <= dois_d;
            fim_q           <= fim_d;
        end
    end

    assign DEZ         = dez_q;
    assign DOIS        = dois_q;
    assign FIM         = fim_q;
    assign moneyState  = money_state_q;
    assign moneyToGive = money_to_give_q;
    assign mainState   = state_q;

`ifdef BARCODE_MESSAGE_EN
    barcode_msg_rom u_msg_rom (
        .state   (state_q),
        .message (message)
    );
`else
    assign message = '0;
`endif

endmodule

// File: tb/tb_barcode_checkout.sv
// Self-checking bench for barcode_checkout: transaction-level reference model,
// directed scenarios with literal expectations, then randomized price/payment traffic.
module tb_barcode_checkout;

    logic         clock;
    logic         reset;
    logic [4:0]   I;
    logic [4:0]   PG;
    logic         DEZ;
    logic         DOIS;
    logic         FIM;
    logic [4:0]   moneyState;
    logic [4:0]   moneyToGive;
    logic [2:0]   mainState;
    logic [207:0] message;

    int errors = 0;
    int checks = 0;

    barcode_checkout dut (
        .clock       (clock),
        .reset       (reset),
        .I           (I),
        .PG          (PG),
        .DEZ         (DEZ),
        .DOIS        (DOIS),
        .FIM         (FIM),
        .moneyState  (moneyState),
        .moneyToGive (moneyToGive),
        .mainState   (mainState),
        .message     (message)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Reference model: phase codes are the externally visible mainState values.
    int m_phase;
    int m_price;
    int m_paid;
    int m_owed;
    int m_dez;
    int m_dois;
    int m_fim;
    int m_coins[$];

    task automatic check(input string name, input logic [207:0] actual, input logic [207:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

`ifdef BARCODE_MESSAGE_EN
    function automatic logic [207:0] pad(input string s);
        logic [207:0] r;
        r = {26{8'h20}};
        for (int i = 0; i < s.len(); i++) r[207-8*i -: 8] = s[i];
        return r;
    endfunction

    function automatic logic [207:0] exp_msg(input int phase);
        case (phase)
            1:       return pad("INSERT PAYMENT");
            2:       return pad("DISPENSING CHANGE");
            3:       return pad("THANK YOU");
            4:       return pad("INSUFFICIENT FUNDS");
            default: return pad("SCAN ITEM");
        endcase
    endfunction
`endif

    task automatic model_reset();
        m_phase = 0; m_price = 0; m_paid = 0; m_owed = 0;
        m_dez = 0; m_dois = 0; m_fim = 0;
        m_coins.delete();
    endtask

    // Change plan: as many tens as fit, then twos from the remainder.
    task automatic plan_change(input int amount);
        m_coins.delete();
        for (int k = 0; k < amount / 10; k++) m_coins.push_back(10);
        for (int k = 0; k < (amount % 10) / 2; k++) m_coins.push_back(2);
    endtask

    task automatic model_step();
        int coin;
        m_dez = 0;
        m_dois = 0;
        case (m_phase)
            0: if (I != 0) begin
                m_price = int'(I);
                m_paid  = 0;
                m_phase = 1;
            end
            1: if (PG != 0) begin
                m_paid = int'(PG);
                if (m_paid >= m_price) begin
                    m_owed  = m_paid - m_price;
                    m_phase = 2;
                end else begin
                    m_owed  = m_paid;
                    m_phase = 4;
                end
                plan_change(m_owed);
            end
            4: m_phase = 2;
            2: if (m_coins.size() > 0) begin
                coin = m_coins.pop_front();
                if (coin == 10) m_dez = 1;
                else            m_dois = 1;
                m_owed -= coin;
            end else begin
                m_phase = 3;
            end
            3: if (I == 0 && PG == 0) begin
                m_phase = 0;
                m_owed  = 0;
            end
            default: m_phase = 0;
        endcase
        m_fim = (m_phase == 3) ? 1 : 0;
    endtask

    task automatic compare_all();
        check("cyc_DEZ",         208'(DEZ),         208'(m_dez));
        check("cyc_DOIS",        208'(DOIS),        208'(m_dois));
        check("cyc_FIM",         208'(FIM),         208'(m_fim));
        check("cyc_mainState",   208'(mainState),   208'(m_phase));
        check("cyc_moneyState",  208'(moneyState),  208'(m_paid));
        check("cyc_moneyToGive", 208'(moneyToGive), 208'(m_owed));
        check("cyc_coin_excl",   208'(DEZ & DOIS),  208'(0));
`ifdef BARCODE_MESSAGE_EN
        check("cyc_message",     message,           exp_msg(m_phase));
`else
        check("cyc_message",     message,           208'(0));
`endif
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        @(negedge clock);
        compare_all();
    endtask

    // Holds price/payment until FIM, then releases inputs; literal results pin the model.
    task automatic run_txn(input int price, input int pay, input int exp_first, input int exp_ndez,
                           input int exp_ndois, input int exp_res, input int exp_refund);
        int  ndez, ndois, first, saw_refund;
        bit  got_first;
        string tag;
        ndez = 0; ndois = 0; first = -1; saw_refund = 0; got_first = 0;
        tag = $sformatf("txn_%0d_%0d", price, pay);
        I  = 5'(price);
        PG = 5'(pay);
        for (int k = 0; k < 20; k++) begin
            tick();
            if (!got_first && (mainState == 3'd2 || mainState == 3'd4)) begin
                got_first = 1;
                first = int'(moneyToGive);
            end
            if (mainState == 3'd4) begin
                saw_refund = 1;
`ifdef BARCODE_MESSAGE_EN
                check({tag, "_refund_msg"}, message, pad("INSUFFICIENT FUNDS"));
`else
                check({tag, "_refund_msg"}, message, 208'(0));
`endif
            end
            ndez  += int'(DEZ);
            ndois += int'(DOIS);
            if (FIM) break;
        end
        check({tag, "_fim"},        208'(FIM),         208'(1));
        check({tag, "_paid"},       208'(moneyState),  208'(pay));
        check({tag, "_first_owed"}, 208'(first),       208'(exp_first));
        check({tag, "_ndez"},       208'(ndez),        208'(exp_ndez));
        check({tag, "_ndois"},      208'(ndois),       208'(exp_ndois));
        check({tag, "_residue"},    208'(moneyToGive), 208'(exp_res));
        check({tag, "_refund"},     208'(saw_refund),  208'(exp_refund));
        tick();
        check({tag, "_held_done"},  208'(mainState),   208'(3));
        I  = 5'd0;
        PG = 5'd0;
        tick();
        check({tag, "_back_idle"},  208'(mainState),   208'(0));
    endtask

    initial begin
        reset = 1'b0;
        I     = 5'd0;
        PG    = 5'd0;
        model_reset();
        repeat (2) @(negedge clock);
        compare_all();
        check("reset_mainState", 208'(mainState), 208'(0));
        check("reset_FIM",       208'(FIM),       208'(0));
        reset = 1'b1;
        tick();

        run_txn(10, 31, 21, 2, 0, 1, 0);
        run_txn(20, 31, 11, 1, 0, 1, 0);
        run_txn(30, 31,  1, 0, 0, 1, 0);
        run_txn(14, 30, 16, 1, 3, 0, 0);
        run_txn(20,  6,  6, 0, 3, 0, 1);

        // Asynchronous reset while a DEZ pulse is on the outputs.
        I  = 5'd1;
        PG = 5'd31;
        for (int k = 0; k < 10 && !DEZ; k++) tick();
        check("pre_reset_DEZ", 208'(DEZ), 208'(1));
        #2 reset = 1'b0;
        #1;
        model_reset();
        check("async_DEZ",         208'(DEZ),         208'(0));
        check("async_DOIS",        208'(DOIS),        208'(0));
        check("async_FIM",         208'(FIM),         208'(0));
        check("async_mainState",   208'(mainState),   208'(0));
        check("async_moneyToGive", 208'(moneyToGive), 208'(0));
`ifdef BARCODE_MESSAGE_EN
        check("async_message", message, pad("SCAN ITEM"));
`else
        check("async_message", message, 208'(0));
`endif
        I  = 5'd0;
        PG = 5'd0;
        #1 reset = 1'b1;
        tick();

        // Random traffic: zero is drawn often so idle/done exits actually happen.
        for (int n = 0; n < 3000; n++) begin
            I  = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            PG = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
